// File: rtl/ram_io_responder_pkg.sv
// Address map and bus-target decode shared by the memory/I/O responder.
package ram_io_responder_pkg;

    localparam logic [1:0]  IO_SEL  = 2'b11;
    localparam logic [17:0] IO_UART = 18'h30000;
    localparam logic [17:0] IO_CLK  = 18'h30004;

    typedef enum logic [1:0] {T_RAM, T_UART, T_CLK, T_NONE} io_target_t;

    // The clock window spans four byte addresses; UART is a single address.
    function automatic io_target_t decode_target(input logic [17:0] a);
        if (a[17:16] != IO_SEL) return T_RAM;
        if (a == IO_UART) return T_UART;
        if (a[17:2] == IO_CLK[17:2]) return T_CLK;
        return T_NONE;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO with a registered head word and a registered almost-full flag.
module byte_fifo #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int AF_FREE = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    logic [AW:0]      count_next;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A pop frees its slot first, so a full FIFO still accepts a simultaneous push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count_next = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            head        <= '0;
            almost_full <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count       <= count_next;
            almost_full <= (DEPTH - int'(count_next)) <= AF_FREE;
            if (count_next == '0)
                head <= '0;
            else if (do_pop)
                head <= (count == ONE_CNT) ? push_data : mem[rd_ptr + AW'(1)];
            else if (empty)
                head <= push_data;
        end
    end

endmodule

// File: rtl/ram_io_responder.sv
// Responder for the CPU byte bus: on-chip RAM plus UART, cycle-counter and stop ports.
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_W    = 17,
    parameter int TX_FIFO_DEPTH = 8,
    parameter int FULL_MARGIN   = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        program_end
);
    io_target_t            target, target_q;
    logic [RAM_ADDR_W-1:0] ram_addr;
    logic [7:0]            ram [2**RAM_ADDR_W];
    logic [7:0]            ram_q, io_q;
    logic [31:0]           clk_cnt, snap;
    logic                  tx_push, tx_pop, tx_empty;
    logic [7:0]            tx_push_data;
    logic                  stop_write;
    logic [$clog2(TX_FIFO_DEPTH):0] tx_count_unused;
    logic                  tx_full_unused;
    logic                  addr_hi_unused;

    assign target         = decode_target(mem_a[17:0]);
    assign ram_addr       = mem_a[RAM_ADDR_W-1:0];
    assign addr_hi_unused = ^mem_a[31:18];
    assign stop_write     = mem_wr && (target == T_CLK) && (mem_a[1:0] == 2'b00);

    // RAM holds no reset; the write is suppressed while reset is asserted.
    always_ff @(posedge clk_in) begin
        if (!rst_in && mem_wr && target == T_RAM) ram[ram_addr] <= mem_dout;
        ram_q <= ram[ram_addr];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            clk_cnt     <= '0;
            snap        <= '0;
            io_q        <= '0;
            rx_pop      <= 1'b0;
            program_end <= 1'b0;
            target_q    <= T_NONE;
        end else begin
            clk_cnt  <= clk_cnt + 32'd1;
            rx_pop   <= 1'b0;
            io_q     <= 8'h00;
            target_q <= mem_wr ? T_NONE : target;
            if (stop_write) program_end <= 1'b1;
            if (!mem_wr) begin
                case (target)
                    T_UART: if (rx_valid) begin
                        io_q   <= rx_data;
                        rx_pop <= 1'b1;
                    end
                    // Byte 0 refreshes the snapshot so a 4-byte read sees one coherent value.
                    T_CLK: if (mem_a[1:0] == 2'b00) begin
                        snap <= clk_cnt;
                        io_q <= clk_cnt[7:0];
                    end else begin
                        io_q <= snap[{mem_a[1:0], 3'b000} +: 8];
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mem_din = (target_q == T_RAM) ? ram_q : io_q;

    always_comb begin
        tx_push      = 1'b0;
        tx_push_data = mem_dout;
        if (mem_wr && target == T_UART && mem_dout != 8'h00) begin
            tx_push = 1'b1;
        end else if (stop_write) begin
            tx_push      = 1'b1;
            tx_push_data = 8'h00;
        end
    end

    assign tx_valid = !tx_empty;
    assign tx_pop   = tx_valid && tx_ready;

    byte_fifo #(
        .WIDTH   (8),
        .DEPTH   (TX_FIFO_DEPTH),
        .AF_FREE (FULL_MARGIN)
    ) u_tx_fifo (
        .clk         (clk_in),
        .rst         (rst_in),
        .push        (tx_push),
        .push_data   (tx_push_data),
        .pop         (tx_pop),
        .head        (tx_data),
        .count       (tx_count_unused),
        .full        (tx_full_unused),
        .empty       (tx_empty),
        .almost_full (io_buffer_full)
    );

endmodule
